// File: rtl/fifo_param_pkg.sv
// Shared types for the fifo_param block: the per-cycle operation encoding
// used to update occupancy.
package fifo_param_pkg;

  // What the FIFO actually does on a clock edge, after acceptance rules.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_BOTH  = 2'd3
  } fifo_op_e;

  // Collapse accepted write/read strobes into a single operation code.
  function automatic fifo_op_e fifo_op(input logic wr_ok, input logic rd_ok);
    return fifo_op_e'({wr_ok, rd_ok});
  endfunction

endpackage

// File: rtl/fifo_defs.vh
// Shared helpers for the fifo_param block: a constant clog2 and
// elaboration-time legality checks on the parameter set.
// Included inside the fifo_param module body so the checks see its parameters.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

// Ceiling log2 usable in constant expressions (returns 0 for value <= 1).
function automatic int fifo_clog2(input int value);
  int result;
  result = 0;
  for (int i = 0; i < 31; i++) begin
    if ((1 << i) < value) begin
      result = i + 1;
    end
  end
  return result;
endfunction

// Parameter legality: stop elaboration on an unusable configuration.
if (DATA_WIDTH < 1) begin : g_bad_width
  $error("fifo_param: DATA_WIDTH must be >= 1");
end
if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
  $error("fifo_param: DEPTH must be a power of two and >= 2");
end
if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
  $error("fifo_param: AF_THRESH must lie in 1..DEPTH");
end
if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
  $error("fifo_param: AE_THRESH must lie in 0..DEPTH-1");
end
if ((SHOW_AHEAD != 0) && (SHOW_AHEAD != 1)) begin : g_bad_mode
  $error("fifo_param: SHOW_AHEAD must be 0 or 1");
end

`endif

// File: rtl/fifo_mem.sv
// Storage array for fifo_param: one synchronous write port, one
// asynchronous read port, no reset (contents are don't-care until written).
module fifo_mem
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head-of-queue data is presented without a clock so the controller can
  // either register it or pass it straight through.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO: pointers, occupancy, status/error flags
// and the output stage. Storage lives in fifo_mem.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int SHOW_AHEAD = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  `include "fifo_defs.vh"

  localparam int PTR_W = fifo_clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL    = CNT_W'(AE_THRESH);

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  full_reg;
  logic                  empty_reg;
  logic                  almost_full_reg;
  logic                  almost_empty_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_hit;
  logic                  unf_hit;
  fifo_op_e              op;
  logic [DATA_WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_reg),
    .wdata (data_in),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  // Acceptance rules: flush wins over everything; a read frees a slot so a
  // write into a full FIFO is still taken when a read happens alongside it.
  always_comb begin
    rd_ok   = 1'b0;
    wr_ok   = 1'b0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    if (!flush) begin
      rd_ok   = rd_en && !empty_reg;
      wr_ok   = wr_en && (!full_reg || rd_ok);
      ovf_hit = wr_en && !wr_ok;
      unf_hit = rd_en && empty_reg;
    end
  end

  // Next occupancy from the accepted operation; flush empties the FIFO.
  always_comb begin
    op         = fifo_op(wr_ok, rd_ok);
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case (op)
        OP_WRITE: count_next = count_reg + CNT_W'(1);
        OP_READ:  count_next = count_reg - CNT_W'(1);
        default:  count_next = count_reg;
      endcase
    end
  end

  // Pointer update; natural binary wrap works because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Occupancy and level flags are all registered from the same next count so
  // they can never disagree with each other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      count_reg        <= count_next;
      full_reg         <= (count_next == DEPTH_LVL);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_LVL);
      almost_empty_reg <= (count_next <= AE_LVL);
    end
  end

  // Sticky error flags: set on a rejected request, cleared only by reset/flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_reg  | ovf_hit;
      underflow_reg <= underflow_reg | unf_hit;
    end
  end

  // Output stage: registered pop data, or show-ahead head with a hold copy
  // so data_out stays stable on the last head while the FIFO is empty.
  if (SHOW_AHEAD == 0) begin : g_reg_out
    logic [DATA_WIDTH-1:0] dout_reg;

    // Capture the head entry on the edge that accepts a read.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_reg <= '0;
      end else if (rd_ok) begin
        dout_reg <= mem_rdata;
      end
    end

    assign data_out = dout_reg;
  end else begin : g_fwft
    logic [DATA_WIDTH-1:0] head_hold_reg;

    // Track the current head so it can be replayed once the FIFO drains.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        head_hold_reg <= '0;
      end else if (!empty_reg) begin
        head_hold_reg <= mem_rdata;
      end
    end

    assign data_out = empty_reg ? head_hold_reg : mem_rdata;
  end

  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule
